// File: rtl/pc_next_stage.sv
// Program-counter stage: holds the fetch PC, picks jump/branch/sequential next PC,
// and offers it to fetch over a valid/ready handshake with a saturating accept counter.
module pc_next_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] pc,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             fire;
  logic             redirect;
  logic [WIDTH-1:0] sel_target;
  logic [WIDTH-1:0] aligned_target;

  // Jump outranks branch; only the selected target feeds pc and misalign.
  always_comb begin
    fire           = out_valid & out_ready;
    redirect       = jmp_valid | br_valid;
    sel_target     = jmp_valid ? jmp_target : br_target;
    aligned_target = {sel_target[WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      misalign  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      misalign <= redirect && (sel_target[1:0] != 2'b00);

      if (fire && (fetch_cnt != CNT_MAX))
        fetch_cnt <= fetch_cnt + CNT_W'(1);

      // A redirect replaces the offered PC even if fetch never took it.
      if (redirect)
        pc <= aligned_target;
      else if (fire)
        pc <= pc + PC_STEP;

      case (state)
        BOOT, RUN: begin
          if (stall) begin
            state     <= STALL;
            out_valid <= 1'b0;
          end else begin
            state     <= RUN;
            out_valid <= 1'b1;
          end
        end
        STALL: begin
          if (!stall) begin
            state     <= RUN;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= BOOT;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_next_stage.sv
// Self-checking bench for pc_next_stage: directed scenarios plus randomized traffic
// compared against a cycle-level model of the next-PC rules.
module tb_pc_next_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0, br_valid = 1'b0, jmp_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0;
  logic        out_valid, misalign;
  logic [31:0] pc;
  logic [15:0] fetch_cnt;

  logic        rst_n2 = 1'b1;
  logic        stall2 = 1'b0, br_valid2 = 1'b0, jmp_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [31:0] br_target2 = '0, jmp_target2 = '0;
  logic        out_valid2, misalign2;
  logic [31:0] pc2;
  logic [1:0]  fetch_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_next_stage u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .br_valid(br_valid), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .out_ready(out_ready), .out_valid(out_valid), .pc(pc),
    .misalign(misalign), .fetch_cnt(fetch_cnt)
  );

  pc_next_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .stall(stall2),
    .br_valid(br_valid2), .br_target(br_target2),
    .jmp_valid(jmp_valid2), .jmp_target(jmp_target2),
    .out_ready(out_ready2), .out_valid(out_valid2), .pc(pc2),
    .misalign(misalign2), .fetch_cnt(fetch_cnt2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({out_valid, misalign, pc, fetch_cnt} !== {1'b0, 1'b0, 32'h0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b mis=%b pc=%h cnt=%0d, want 0/0/00000000/0",
               out_valid, misalign, pc, fetch_cnt);
    end
    out_ready = 1'b1;
    rst_n = 1'b1;
    n_cmp++;
    if ({out_valid, pc} !== {1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL boot_cycle: valid=%b pc=%h, want 0/00000000", out_valid, pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("txn seq %0d: pc=%h valid=%b cnt=%0d", i, pc, out_valid, fetch_cnt);
      n_cmp++;
      if ({out_valid, pc, fetch_cnt} !== {1'b1, 32'(4 * i), 16'(i)}) begin
        n_bad++;
        $display("FAIL seq_pc[%0d]: valid=%b pc=%h cnt=%0d, want 1/%h/%0d",
                 i, out_valid, pc, fetch_cnt, 32'(4 * i), i);
      end
    end
  endtask

  task automatic test_ready_hold;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, pc, fetch_cnt} !== {1'b1, 32'h8, 16'd2}) begin
        n_bad++;
        $display("FAIL ready_hold[%0d]: valid=%b pc=%h cnt=%0d, want 1/00000008/2",
                 i, out_valid, pc, fetch_cnt);
      end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({pc, fetch_cnt} !== {32'hC, 16'd3}) begin
      n_bad++;
      $display("FAIL ready_resume: pc=%h cnt=%0d, want 0000000c/3", pc, fetch_cnt);
    end
    tick();
    $display("txn hold done: pc=%h cnt=%0d", pc, fetch_cnt);
  endtask

  task automatic test_redirect;
    jmp_valid = 1'b1; jmp_target = 32'h100;
    br_valid = 1'b1;  br_target = 32'h203;
    tick();
    n_cmp++;
    if ({pc, misalign, fetch_cnt} !== {32'h100, 1'b0, 16'd5}) begin
      n_bad++;
      $display("FAIL jmp_priority: pc=%h mis=%b cnt=%0d, want 00000100/0/5", pc, misalign, fetch_cnt);
    end
    jmp_valid = 1'b0;
    tick();
    n_cmp++;
    if ({pc, misalign, fetch_cnt} !== {32'h200, 1'b1, 16'd6}) begin
      n_bad++;
      $display("FAIL br_misalign: pc=%h mis=%b cnt=%0d, want 00000200/1/6", pc, misalign, fetch_cnt);
    end
    br_valid = 1'b0; out_ready = 1'b0;
    tick();
    n_cmp++;
    if ({pc, misalign} !== {32'h200, 1'b0}) begin
      n_bad++;
      $display("FAIL misalign_pulse: pc=%h mis=%b, want 00000200/0", pc, misalign);
    end
    br_valid = 1'b1; br_target = 32'h300;
    tick();
    n_cmp++;
    if ({out_valid, pc, fetch_cnt} !== {1'b1, 32'h300, 16'd6}) begin
      n_bad++;
      $display("FAIL flush_no_fire: valid=%b pc=%h cnt=%0d, want 1/00000300/6", out_valid, pc, fetch_cnt);
    end
    br_valid = 1'b0;
    $display("txn redirect done: pc=%h cnt=%0d", pc, fetch_cnt);
  endtask

  task automatic test_stall;
    jmp_valid = 1'b1; jmp_target = 32'h20;
    tick();
    jmp_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, pc} !== {1'b0, 32'h20}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h, want 0/00000020", i, out_valid, pc);
      end
    end
    br_valid = 1'b1; br_target = 32'h40;
    tick();
    n_cmp++;
    if ({out_valid, pc} !== {1'b0, 32'h40}) begin
      n_bad++;
      $display("FAIL stall_redirect: valid=%b pc=%h, want 0/00000040", out_valid, pc);
    end
    br_valid = 1'b0; stall = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, pc, fetch_cnt} !== {1'b1, 32'h40, 16'd6}) begin
      n_bad++;
      $display("FAIL stall_release: valid=%b pc=%h cnt=%0d, want 1/00000040/6", out_valid, pc, fetch_cnt);
    end
    // A fire in the same cycle as a stall request still counts and advances pc.
    stall = 1'b1; out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, pc, fetch_cnt} !== {1'b0, 32'h44, 16'd7}) begin
      n_bad++;
      $display("FAIL stall_with_fire: valid=%b pc=%h cnt=%0d, want 0/00000044/7", out_valid, pc, fetch_cnt);
    end
    $display("txn stall done: pc=%h cnt=%0d", pc, fetch_cnt);
  endtask

  task automatic test_reset_mid_stall;
    br_valid = 1'b1; br_target = 32'h81;
    tick();
    n_cmp++;
    if ({out_valid, pc, misalign} !== {1'b0, 32'h80, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_reset: valid=%b pc=%h mis=%b, want 0/00000080/1", out_valid, pc, misalign);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, misalign, pc, fetch_cnt} !== {1'b0, 1'b0, 32'h0, 16'h0}) begin
      n_bad++;
      $display("FAIL async_reset: valid=%b mis=%b pc=%h cnt=%0d, want 0/0/00000000/0",
               out_valid, misalign, pc, fetch_cnt);
    end
    tick();
    br_valid = 1'b0; stall = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, pc} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL post_reset: valid=%b pc=%h, want 1/00000000", out_valid, pc);
    end
  endtask

  task automatic test_wrap_saturate;
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000; exp_pc[3] = 32'h0000_0004;
    rst_n2 = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid2, pc2, fetch_cnt2} !== {1'b0, 32'hFFFF_FFF8, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_pc2: valid=%b pc=%h cnt=%0d, want 0/fffffff8/0", out_valid2, pc2, fetch_cnt2);
    end
    out_ready2 = 1'b1;
    rst_n2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("txn wrap %0d: pc=%h cnt=%0d", i, pc2, fetch_cnt2);
      n_cmp++;
      if (pc2 !== exp_pc[i]) begin
        n_bad++;
        $display("FAIL wrap_pc[%0d]: pc=%h, want %h", i, pc2, exp_pc[i]);
      end
    end
    for (int i = 0; i < 2; i++) tick();
    n_cmp++;
    if (fetch_cnt2 !== 2'd3) begin
      n_bad++;
      $display("FAIL cnt_saturate: cnt=%0d, want 3", fetch_cnt2);
    end
  endtask

  task automatic test_random;
    logic [31:0] m_pc, n_pc, tgt;
    logic        m_valid, m_mis, f;
    logic [15:0] m_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 16'h0;
    for (int i = 0; i < 200; i++) begin
      stall      = ($urandom_range(3) == 0);
      br_valid   = ($urandom_range(3) == 0);
      jmp_valid  = ($urandom_range(6) == 0);
      br_target  = $urandom;
      jmp_target = $urandom;
      out_ready  = $urandom_range(1) == 1;
      f = m_valid && out_ready;
      if (jmp_valid || br_valid) begin
        tgt   = jmp_valid ? jmp_target : br_target;
        n_pc  = tgt - (tgt % 4);
        m_mis = (tgt % 4) != 0;
      end else begin
        n_pc  = f ? m_pc + 32'd4 : m_pc;
        m_mis = 1'b0;
      end
      if (f && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_pc = n_pc;
      m_valid = !stall;
      tick();
      $display("txn rnd %0d: pc=%h valid=%b mis=%b cnt=%0d", i, pc, out_valid, misalign, fetch_cnt);
      n_cmp++;
      if ({out_valid, misalign, pc, fetch_cnt} !== {m_valid, m_mis, m_pc, m_cnt}) begin
        n_bad++;
        $display("FAIL rnd[%0d]: valid=%b mis=%b pc=%h cnt=%0d, want %b/%b/%h/%0d",
                 i, out_valid, misalign, pc, fetch_cnt, m_valid, m_mis, m_pc, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ready_hold();
    test_redirect();
    test_stall();
    test_reset_mid_stall();
    test_wrap_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
